// File: rtl/clint_axi_lite.sv
// AXI-lite responder for the CLINT timer: mtime/mtimecmp registers and registered mtip.
// Read and write channels run as independent FSMs; writes merge byte-wise under WSTRB.

module clint_byte_merge (
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  input  logic       en,
  output logic [7:0] out_byte
);
  assign out_byte = en ? new_byte : old_byte;
endmodule

module clint_axi_lite #(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 64,
  parameter logic [31:0] BASE     = 32'h0200_0000,
  parameter int          TICK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_W-1:0]     WDATA,
  input  logic [DATA_W/8-1:0]   WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic                  BVALID,
  output logic [1:0]            BRESP,
  input  logic                  BREADY,
  input  logic [ADDR_W-1:0]     ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_W-1:0]     RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  mtip
);
  localparam int NB = DATA_W / 8;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'(7);
  localparam logic [ADDR_W-1:0] CMP_ADDR  = ADDR_W'(BASE + 32'h4000) & ~LOW_MASK;
  localparam logic [ADDR_W-1:0] TIME_ADDR = ADDR_W'(BASE + 32'hBFF8) & ~LOW_MASK;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_RESP} rstate_t;

  function automatic logic is_cmp(input logic [ADDR_W-1:0] a);
    return (a & ~LOW_MASK) == CMP_ADDR;
  endfunction

  function automatic logic is_time(input logic [ADDR_W-1:0] a);
    return (a & ~LOW_MASK) == TIME_ADDR;
  endfunction

  logic [DATA_W-1:0] mtime, mtimecmp;
  logic [TW-1:0]     tick_cnt;
  logic              tick;

  // ---------------- write path ----------------
  wstate_t           w_state, w_next;
  logic              aw_hs, w_hs, wr_fire, wr_is_cmp, wr_is_time;
  logic [ADDR_W-1:0] aw_addr_q, wr_addr;
  logic [DATA_W-1:0] wdata_q, wr_data, wr_old, wr_merged;
  logic [NB-1:0]     wstrb_q, wr_strb;

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_next = W_RESP;
        else if (aw_hs)    w_next = W_HAVE_AW;
        else if (w_hs)     w_next = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)   w_next = W_RESP;
      W_HAVE_W:  if (aw_hs)  w_next = W_RESP;
      W_RESP:    if (BREADY) w_next = W_IDLE;
      default:               w_next = W_IDLE;
    endcase
  end

  always_comb begin
    AWREADY = (w_state == W_IDLE) || (w_state == W_HAVE_W);
    WREADY  = (w_state == W_IDLE) || (w_state == W_HAVE_AW);
    BVALID  = (w_state == W_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (aw_hs) aw_addr_q <= AWADDR;
      if (w_hs) begin
        wdata_q <= WDATA;
        wstrb_q <= WSTRB;
      end
    end
  end

  // The write commits on the edge that completes the AW/W pair, so the
  // half arriving this cycle is taken live and the other from its latch.
  assign wr_fire    = (w_state != W_RESP) && (w_next == W_RESP);
  assign wr_addr    = (w_state == W_HAVE_AW) ? aw_addr_q : AWADDR;
  assign wr_data    = (w_state == W_HAVE_W)  ? wdata_q   : WDATA;
  assign wr_strb    = (w_state == W_HAVE_W)  ? wstrb_q   : WSTRB;
  assign wr_is_cmp  = is_cmp(wr_addr);
  assign wr_is_time = is_time(wr_addr);
  assign wr_old     = wr_is_time ? mtime : mtimecmp;

  for (genvar b = 0; b < NB; b++) begin : g_byte
    clint_byte_merge u_merge (
      .old_byte (wr_old[8*b +: 8]),
      .new_byte (wr_data[8*b +: 8]),
      .en       (wr_strb[b]),
      .out_byte (wr_merged[8*b +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)          BRESP <= 2'b00;
    else if (wr_fire) BRESP <= (wr_is_cmp || wr_is_time) ? 2'b00 : 2'b10;
  end

  // ---------------- read path ----------------
  rstate_t r_state, r_next;
  logic    ar_hs;

  assign ar_hs = ARVALID & ARREADY;

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ARVALID) r_next = R_RESP;
      R_RESP:  if (RREADY)  r_next = R_IDLE;
      default:              r_next = R_IDLE;
    endcase
  end

  always_comb begin
    ARREADY = (r_state == R_IDLE);
    RVALID  = (r_state == R_RESP);
  end

  // Captured from the pre-edge register values, so a same-cycle write is not seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      RDATA <= '0;
      RRESP <= 2'b00;
    end else if (ar_hs) begin
      if (is_time(ARADDR)) begin
        RDATA <= mtime;
        RRESP <= 2'b00;
      end else if (is_cmp(ARADDR)) begin
        RDATA <= mtimecmp;
        RRESP <= 2'b00;
      end else begin
        RDATA <= '0;
        RRESP <= 2'b10;
      end
    end
  end

  // ---------------- timer ----------------
  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
      mtip     <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      if (wr_fire && wr_is_time) mtime <= wr_merged;
      else if (tick)             mtime <= mtime + DATA_W'(1);
      if (wr_fire && wr_is_cmp)  mtimecmp <= wr_merged;
      mtip <= (mtime >= mtimecmp);
    end
  end
endmodule

// File: tb/tb_clint_axi_lite.sv
// Directed bench for clint_axi_lite (TICK_DIV=1): timing, byte merge, decode, stalls, reset abort.
module tb_clint_axi_lite;
  localparam logic [31:0] BASE   = 32'h0200_0000;
  localparam logic [31:0] A_CMP  = BASE + 32'h4000;
  localparam logic [31:0] A_TIME = BASE + 32'hBFF8;
  localparam logic [31:0] A_BAD  = BASE + 32'h0100;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] AWADDR = '0, ARADDR = '0;
  logic        AWVALID = 1'b0, WVALID = 1'b0, ARVALID = 1'b0;
  logic        BREADY = 1'b1, RREADY = 1'b1;
  logic [63:0] WDATA = '0;
  logic [7:0]  WSTRB = '0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID, mtip;
  logic [1:0]  BRESP, RRESP;
  logic [63:0] RDATA;

  int          tests = 0, fails = 0;
  logic [63:0] ticks;

  clint_axi_lite #(.ADDR_W(32), .DATA_W(64), .BASE(BASE), .TICK_DIV(1)) dut (
    .clk(clk), .rst(rst),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .mtip(mtip)
  );

  always #5 clk = ~clk;

  // Cycles since reset release: the expected mtime while nothing writes it.
  always @(posedge clk) begin
    if (rst) ticks <= '0;
    else     ticks <= ticks + 64'd1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                    output logic [1:0] resp);
    int n;
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
    step();
    AWVALID = 1'b0; WVALID = 1'b0;
    n = 0;
    while (!BVALID && n < 20) begin step(); n++; end
    chk("wr_bvalid", 64'(BVALID), 64'd1);
    resp = BRESP;
    step();
  endtask

  task automatic rd(input logic [31:0] a, output logic [63:0] d, output logic [1:0] resp);
    int n;
    ARADDR = a; ARVALID = 1'b1;
    step();
    ARVALID = 1'b0;
    n = 0;
    while (!RVALID && n < 20) begin step(); n++; end
    chk("rd_rvalid", 64'(RVALID), 64'd1);
    d = RDATA; resp = RRESP;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    logic [1:0]  r;
    int          n;

    // reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_awready", 64'(AWREADY), 64'd1);
    chk("rst_wready",  64'(WREADY),  64'd1);
    chk("rst_arready", 64'(ARREADY), 64'd1);
    chk("rst_bvalid",  64'(BVALID),  64'd0);
    chk("rst_rvalid",  64'(RVALID),  64'd0);
    chk("rst_rdata",   RDATA,        64'd0);
    chk("rst_mtip",    64'(mtip),    64'd0);

    // free-running mtime: 10 cycles after reset
    repeat (10) step();
    rd(A_TIME, d, r);
    chk("mtime_10", d, 64'd10);
    chk("mtime_rresp", 64'(r), 64'd0);
    chk("mtip_idle", 64'(mtip), 64'd0);

    // mtimecmp=0x20, AW two cycles ahead of W
    AWADDR = A_CMP; AWVALID = 1'b1;
    step();
    AWVALID = 1'b0;
    chk("aw_held_awready", 64'(AWREADY), 64'd0);
    chk("aw_held_wready",  64'(WREADY),  64'd1);
    step();
    chk("aw_held_bvalid",  64'(BVALID),  64'd0);
    WDATA = 64'h20; WSTRB = 8'hFF; WVALID = 1'b1;
    step();
    WVALID = 1'b0;
    chk("cmp_bvalid",  64'(BVALID),  64'd1);
    chk("cmp_bresp",   64'(BRESP),   64'd0);
    chk("cmp_awready", 64'(AWREADY), 64'd0);
    step();
    chk("cmp_bdone",   64'(BVALID),  64'd0);
    chk("cmp_aw_free", 64'(AWREADY), 64'd1);
    n = 0;
    while (ticks != 64'h20 && n < 100) begin step(); n++; end
    chk("mtip_at_eq", 64'(mtip), 64'd0);
    step();
    chk("mtip_rise",  64'(mtip), 64'd1);

    // mtime near wrap, AW and W together
    AWADDR = A_TIME; WDATA = 64'hFFFF_FFFF_FFFF_FFFE; WSTRB = 8'hFF;
    AWVALID = 1'b1; WVALID = 1'b1;
    step();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("time_bvalid", 64'(BVALID), 64'd1);
    chk("time_bresp",  64'(BRESP),  64'd0);
    step();
    chk("time_bdone",  64'(BVALID), 64'd0);
    step();
    chk("mtip_top",    64'(mtip),   64'd1);
    ARADDR = A_TIME; ARVALID = 1'b1;
    step();
    ARVALID = 1'b0;
    chk("wrap_rvalid", 64'(RVALID), 64'd1);
    chk("wrap_rdata",  RDATA,       64'd0);
    chk("mtip_wrap",   64'(mtip),   64'd0);
    step();
    rd(A_TIME, d, r);
    chk("after_wrap", d, 64'd2);

    // partial strobe merge into mtimecmp
    wr(A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r);
    chk("cmp_ones_bresp", 64'(r), 64'd0);
    wr(A_CMP, 64'h1111_2222_3333_4444, 8'h0F, r);
    rd(A_CMP, d, r);
    chk("strb_merge", d, 64'hFFFF_FFFF_3333_4444);

    // unmapped address
    wr(A_BAD, 64'hDEAD_BEEF, 8'hFF, r);
    chk("bad_bresp", 64'(r), 64'd2);
    rd(A_CMP, d, r);
    chk("bad_nochange", d, 64'hFFFF_FFFF_3333_4444);
    rd(A_BAD, d, r);
    chk("bad_rdata", d, 64'd0);
    chk("bad_rresp", 64'(r), 64'd2);

    // back-pressure with same-cycle read and write of mtimecmp
    BREADY = 1'b0; RREADY = 1'b0;
    AWADDR = A_CMP; WDATA = 64'h1234; WSTRB = 8'hFF; ARADDR = A_CMP;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    step();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_bvalid",  64'(BVALID),  64'd1);
      chk("stall_rvalid",  64'(RVALID),  64'd1);
      chk("stall_rdata",   RDATA,        64'hFFFF_FFFF_3333_4444);
      chk("stall_bresp",   64'(BRESP),   64'd0);
      chk("stall_awready", 64'(AWREADY), 64'd0);
      chk("stall_arready", 64'(ARREADY), 64'd0);
      step();
    end
    BREADY = 1'b1; RREADY = 1'b1;
    step();
    chk("release_bvalid",  64'(BVALID),  64'd0);
    chk("release_rvalid",  64'(RVALID),  64'd0);
    chk("release_awready", 64'(AWREADY), 64'd1);
    chk("release_arready", 64'(ARREADY), 64'd1);
    rd(A_CMP, d, r);
    chk("stall_write", d, 64'h1234);

    // reset with an AW pending discards it
    AWADDR = A_CMP; AWVALID = 1'b1;
    step();
    AWVALID = 1'b0;
    chk("pend_awready", 64'(AWREADY), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_awready", 64'(AWREADY), 64'd1);
    chk("abort_wready",  64'(WREADY),  64'd1);
    chk("abort_bvalid",  64'(BVALID),  64'd0);
    chk("abort_mtip",    64'(mtip),    64'd0);
    WDATA = 64'd0; WSTRB = 8'hFF; WVALID = 1'b1;
    step();
    WVALID = 1'b0;
    chk("abort_w_only",  64'(BVALID),  64'd0);
    chk("abort_w_held",  64'(WREADY),  64'd0);
    AWADDR = A_BAD; AWVALID = 1'b1;
    step();
    AWVALID = 1'b0;
    chk("abort_bvalid2", 64'(BVALID),  64'd1);
    chk("abort_bresp",   64'(BRESP),   64'd2);
    step();
    rd(A_CMP, d, r);
    chk("abort_cmp_ones", d, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
